// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: control-bus layout, FSM states,
// and small helpers used by the ID/EX stage.
package mips_pipe_pkg;

  localparam int CTRL_W          = 10;
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_REG_DST    = 5;
  localparam int CTRL_ALU_OP_LSB = 6;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic logic [4:0] sel_dest(
    input logic       reg_dst,
    input logic [4:0] rd,
    input logic [4:0] rt
  );
    return reg_dst ? rd : rt;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator between the load in EX and
// the instruction currently decoded in ID.
module load_use_detect
  import mips_pipe_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_dest,
  output logic       load_use
);

  logic rs_hit;
  logic rt_hit;

  always_comb begin
    rs_hit   = id_uses_rs && (id_rs == ex_dest);
    rt_hit   = id_uses_rt && (id_rt == ex_dest);
    load_use = id_valid && ex_valid && ex_mem_read &&
               (ex_dest != REG_ZERO) && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, memory freeze and flush.
// Define HAZARD_STATS_EN to add saturating bubble/hold counters.
module id_ex_stage
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = mips_pipe_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_data1,
  input  logic [DATA_W-1:0] id_data2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              mem_busy,
  input  logic              ex_flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_dest,
  output logic [DATA_W-1:0] ex_data1,
  output logic [DATA_W-1:0] ex_data2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       hold_cnt
`endif
);

  state_e state_q, state_d;
  logic   flush_pend_q, flush_pend_d;
  logic   load_use;
  logic   bubble;

  logic              valid_q, valid_d;
  logic [4:0]        rs_q, rs_d;
  logic [4:0]        rt_q, rt_d;
  logic [4:0]        dest_q, dest_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic [DATA_W-1:0] data2_q, data2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  load_use_detect u_lud (
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q[CTRL_MEM_READ]),
    .ex_dest     (dest_q),
    .load_use    (load_use)
  );

  assign stall = mem_busy | load_use;

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    bubble       = 1'b0;
    valid_d      = valid_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    dest_d       = dest_q;
    data1_d      = data1_q;
    data2_d      = data2_q;
    imm_d        = imm_q;
    ctrl_d       = ctrl_q;

    case (state_q)
      RUN:  if (mem_busy)  state_d = HOLD;
      HOLD: if (!mem_busy) state_d = RUN;
      default:             state_d = RUN;
    endcase

    // A flush seen while frozen is remembered and applied on release.
    if (mem_busy) begin
      if (ex_flush) flush_pend_d = 1'b1;
    end else if (ex_flush || flush_pend_q) begin
      bubble       = 1'b1;
      flush_pend_d = 1'b0;
    end else if (load_use) begin
      bubble = 1'b1;
    end else begin
      valid_d = id_valid;
      rs_d    = id_rs;
      rt_d    = id_rt;
      dest_d  = sel_dest(id_ctrl[CTRL_REG_DST], id_rd, id_rt);
      data1_d = id_data1;
      data2_d = id_data2;
      imm_d   = id_imm;
      ctrl_d  = id_valid ? id_ctrl : '0;
    end

    if (bubble) begin
      valid_d = 1'b0;
      rs_d    = '0;
      rt_d    = '0;
      dest_d  = '0;
      data1_d = '0;
      data2_d = '0;
      imm_d   = '0;
      ctrl_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      flush_pend_q <= 1'b0;
      valid_q      <= 1'b0;
      rs_q         <= '0;
      rt_q         <= '0;
      dest_q       <= '0;
      data1_q      <= '0;
      data2_q      <= '0;
      imm_q        <= '0;
      ctrl_q       <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      dest_q       <= dest_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      imm_q        <= imm_d;
      ctrl_q       <= ctrl_d;
    end
  end

  assign ex_valid = valid_q;
  assign ex_rs    = rs_q;
  assign ex_rt    = rt_q;
  assign ex_dest  = dest_q;
  assign ex_data1 = data1_q;
  assign ex_data2 = data2_q;
  assign ex_imm   = imm_q;
  assign ex_ctrl  = ctrl_q;

`ifdef HAZARD_STATS_EN
  logic        lu_ins;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;

  always_comb begin
    lu_ins       = !mem_busy && !ex_flush && !flush_pend_q && load_use;
    bubble_cnt_d = bubble_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    if (lu_ins && (bubble_cnt_q != '1))
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    if ((state_q == HOLD) && (hold_cnt_q != '1))
      hold_cnt_d = hold_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt_q <= '0;
      hold_cnt_q   <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign hold_cnt   = hold_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage: load-use bubbles,
// memory freeze with pending flush, dest select and async reset.
module tb_id_ex_stage;
  import mips_pipe_pkg::*;

  localparam logic [9:0] LW    = 10'h01B;
  localparam logic [9:0] ADD   = 10'h0A1;
  localparam logic [9:0] ADDI  = 10'h091;
  localparam logic [9:0] ADDRT = 10'h081;

  typedef struct packed {
    logic        v;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [9:0]  ctrl;
  } ex_t;

  logic        clk, reset;
  logic        id_valid, id_uses_rs, id_uses_rt;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_data1, id_data2, id_imm;
  logic [9:0]  id_ctrl;
  logic        mem_busy, ex_flush, stall;
  logic        ex_valid;
  logic [4:0]  ex_rs, ex_rt, ex_dest;
  logic [31:0] ex_data1, ex_data2, ex_imm;
  logic [9:0]  ex_ctrl;
`ifdef HAZARD_STATS_EN
  logic [31:0] bubble_cnt, hold_cnt;
`endif

  ex_t sb[$];
  ex_t last;
  ex_t zero_rec;
  int  vectors = 0;
  int  miscompares = 0;

  id_ex_stage #(.DATA_W(32), .CTRL_W(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rd      (id_rd),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .id_data1   (id_data1),
    .id_data2   (id_data2),
    .id_imm     (id_imm),
    .id_ctrl    (id_ctrl),
    .mem_busy   (mem_busy),
    .ex_flush   (ex_flush),
    .stall      (stall),
    .ex_valid   (ex_valid),
    .ex_rs      (ex_rs),
    .ex_rt      (ex_rt),
    .ex_dest    (ex_dest),
    .ex_data1   (ex_data1),
    .ex_data2   (ex_data2),
    .ex_imm     (ex_imm),
    .ex_ctrl    (ex_ctrl)
`ifdef HAZARD_STATS_EN
    ,
    .bubble_cnt (bubble_cnt),
    .hold_cnt   (hold_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ex(input string tag, input ex_t e);
    chk({tag, ".valid"}, {31'b0, ex_valid}, {31'b0, e.v});
    chk({tag, ".rs"},    {27'b0, ex_rs},    {27'b0, e.rs});
    chk({tag, ".rt"},    {27'b0, ex_rt},    {27'b0, e.rt});
    chk({tag, ".dest"},  {27'b0, ex_dest},  {27'b0, e.dest});
    chk({tag, ".data1"}, ex_data1,          e.d1);
    chk({tag, ".data2"}, ex_data2,          e.d2);
    chk({tag, ".imm"},   ex_imm,            e.imm);
    chk({tag, ".ctrl"},  {22'b0, ex_ctrl},  {22'b0, e.ctrl});
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    #1;
    chk({tag, ".stall"}, {31'b0, stall}, {31'b0, exp});
  endtask

  task automatic drv(input logic v, input logic [4:0] rs,
                     input logic [4:0] rt, input logic [4:0] rd,
                     input logic urs, input logic urt,
                     input logic [31:0] d1, input logic [31:0] d2,
                     input logic [31:0] imm, input logic [9:0] c);
    id_valid   = v;
    id_rs      = rs;
    id_rt      = rt;
    id_rd      = rd;
    id_uses_rs = urs;
    id_uses_rt = urt;
    id_data1   = d1;
    id_data2   = d2;
    id_imm     = imm;
    id_ctrl    = c;
  endtask

  task automatic push_cap(input logic [4:0] dest);
    ex_t e;
    e.v    = id_valid;
    e.rs   = id_rs;
    e.rt   = id_rt;
    e.dest = dest;
    e.d1   = id_data1;
    e.d2   = id_data2;
    e.imm  = id_imm;
    e.ctrl = id_valid ? id_ctrl : 10'h000;
    sb.push_back(e);
  endtask

  task automatic push_bubble();
    sb.push_back(zero_rec);
  endtask

  task automatic push_hold();
    sb.push_back(last);
  endtask

  task automatic tick(input string tag);
    ex_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk_ex(tag, e);
      last = e;
    end
  endtask

  initial begin
    zero_rec = '0;
    last     = '0;
    reset    = 1'b1;
    mem_busy = 1'b0;
    ex_flush = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000);
    #2;
    chk_ex("reset", zero_rec);
    chk_stall("reset", 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // lw $t0 then dependent add: one bubble
    drv(1, 29, 8, 0, 1, 0, 32'd100, 32'd0, 32'd4, LW);
    chk_stall("lw8", 1'b0);
    push_cap(5'd8);
    tick("lw8");
    drv(1, 8, 9, 10, 1, 1, 32'h11, 32'h22, 32'h0, ADD);
    chk_stall("lu_rs", 1'b1);
    push_bubble();
    tick("lu_rs_bubble");
    chk_stall("lu_rs_after", 1'b0);
    push_cap(5'd10);
    tick("lu_rs_add");

    // load into $zero never stalls
    drv(1, 1, 0, 0, 1, 0, 32'h5, 32'h0, 32'h8, LW);
    chk_stall("lw0", 1'b0);
    push_cap(5'd0);
    tick("lw0");
    drv(1, 0, 0, 11, 1, 1, 32'h0, 32'h0, 32'h0, ADD);
    chk_stall("rs0", 1'b0);
    push_cap(5'd11);
    tick("rs0_add");

    // rt match but rt not read
    drv(1, 1, 9, 0, 1, 0, 32'h7, 32'h0, 32'hC, LW);
    chk_stall("lw9", 1'b0);
    push_cap(5'd9);
    tick("lw9");
    drv(1, 2, 9, 0, 1, 0, 32'h33, 32'h44, 32'hFFFF_FFF0, ADDI);
    chk_stall("itype", 1'b0);
    push_cap(5'd9);
    tick("itype");

    // rt dependency does stall
    drv(1, 4, 9, 0, 1, 0, 32'h9, 32'h0, 32'h10, LW);
    push_cap(5'd9);
    tick("lw9b");
    drv(1, 3, 9, 13, 1, 1, 32'h55, 32'h66, 32'h0, ADD);
    chk_stall("lu_rt", 1'b1);
    push_bubble();
    tick("lu_rt_bubble");
    push_cap(5'd13);
    tick("lu_rt_add");

    // destination select
    drv(1, 6, 5, 12, 1, 1, 32'hA, 32'hB, 32'h0, ADD);
    push_cap(5'd12);
    tick("rdst1");
    drv(1, 6, 5, 12, 1, 1, 32'hC, 32'hD, 32'h0, ADDRT);
    push_cap(5'd5);
    tick("rdst0");

    // 3-cycle memory freeze with flush in cycle 2
    drv(1, 14, 15, 16, 1, 1, 32'hDEAD, 32'hBEEF, 32'h1, ADD);
    mem_busy = 1'b1;
    chk_stall("hold1", 1'b1);
    push_hold();
    tick("hold1");
    ex_flush = 1'b1;
    chk_stall("hold2", 1'b1);
    push_hold();
    tick("hold2");
    ex_flush = 1'b0;
    chk_stall("hold3", 1'b1);
    push_hold();
    tick("hold3");
    mem_busy = 1'b0;
    chk_stall("release", 1'b0);
    push_bubble();
    tick("release_bubble");
    push_cap(5'd16);
    tick("after_release");
`ifdef HAZARD_STATS_EN
    chk("bubble_cnt", bubble_cnt, 32'd2);
    chk("hold_cnt", hold_cnt, 32'd3);
`endif

    // direct flush kills the entering instruction
    drv(1, 17, 7, 0, 1, 0, 32'h99, 32'h0, 32'h20, LW);
    ex_flush = 1'b1;
    push_bubble();
    tick("flush");
    ex_flush = 1'b0;
    push_cap(5'd7);
    tick("post_flush");

    // async reset while frozen
    drv(1, 18, 19, 20, 1, 1, 32'h1, 32'h2, 32'h3, ADD);
    mem_busy = 1'b1;
    push_hold();
    tick("pre_reset_hold");
    #2;
    reset = 1'b1;
    #1;
    chk_ex("async_reset", zero_rec);
    mem_busy = 1'b0;
    chk_stall("async_reset", 1'b0);
`ifdef HAZARD_STATS_EN
    chk("bubble_cnt_rst", bubble_cnt, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    push_cap(5'd20);
    tick("run_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
